// File: rtl/ge_addsub_unit.sv
// Ed25519 point add/subtract: r (ge_p1p1) = p (ge_p3) +/- q (ge_precomp or ge_cached).
// Latency: done in cycle 5 + G*(Lm+1) after start is sampled (Lm = 12 for fe_mul below).
// Backpressure: start is only sampled in IDLE; starts while busy are dropped.

// Limb-wise field add over 10 signed 32-bit limbs (no carry propagation).
module fe_add (
  input  logic [319:0] a,
  input  logic [319:0] b,
  output logic [319:0] y
);
  for (genvar i = 0; i < 10; i++) begin : g_limb
    assign y[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
  end
endmodule

// Limb-wise field subtract over 10 signed 32-bit limbs (no carry propagation).
module fe_sub (
  input  logic [319:0] a,
  input  logic [319:0] b,
  output logic [319:0] y
);
  for (genvar i = 0; i < 10; i++) begin : g_limb
    assign y[32*i +: 32] = a[32*i +: 32] - b[32*i +: 32];
  end
endmodule

// Sequential field multiply (radix 2^25.5, mod 2^255-19): one f limb per cycle, then carry.
// done pulses 12 cycles after the start cycle; h holds until the next completion.
module fe_mul (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [319:0] f,
  input  logic [319:0] g,
  output logic         done,
  output logic [319:0] h
);
  localparam int ORDER [12] = '{0, 4, 1, 5, 2, 6, 3, 7, 4, 8, 9, 0};

  logic [319:0]       fr, gr, h_n;
  logic [3:0]         cnt;
  logic               run;
  logic signed [63:0] acc   [10];
  logic signed [63:0] acc_n [10];

  // Accumulate the partial products of limb f[cnt] against all g limbs.
  always_comb begin : accum
    logic signed [31:0] fi, gj;
    logic signed [63:0] term;
    int ii, k;
    for (int j = 0; j < 10; j++) acc_n[j] = acc[j];
    ii = (cnt < 4'd10) ? int'(cnt) : 0;
    fi = fr[ii*32 +: 32];
    for (int j = 0; j < 10; j++) begin
      gj   = gr[j*32 +: 32];
      term = $signed({{32{fi[31]}}, fi}) * $signed({{32{gj[31]}}, gj});
      // odd x odd limbs carry an extra factor 2; wrap-around terms fold by 19
      if ((ii % 2 == 1) && (j % 2 == 1)) term = term * 64'sd2;
      if (ii + j >= 10) term = term * 64'sd19;
      k = (ii + j) % 10;
      acc_n[k] = acc_n[k] + term;
    end
  end

  // Carry chain bringing limbs back to alternating 26/25-bit form.
  always_comb begin : carry
    logic signed [63:0] t [10];
    logic signed [63:0] c;
    int k, w;
    for (int i = 0; i < 10; i++) t[i] = acc[i];
    for (int n = 0; n < 12; n++) begin
      k = ORDER[n];
      w = (k % 2 == 1) ? 25 : 26;
      c = (t[k] + (64'sd1 <<< (w - 1))) >>> w;
      t[k] = t[k] - (c <<< w);
      if (k == 9) t[0] = t[0] + c * 64'sd19;
      else        t[k + 1] = t[k + 1] + c;
    end
    h_n = '0;
    for (int i = 0; i < 10; i++) h_n[32*i +: 32] = t[i][31:0];
  end

  // Operand latch, limb sequencing and result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fr <= '0; gr <= '0; h <= '0; cnt <= '0; run <= 1'b0; done <= 1'b0;
      for (int i = 0; i < 10; i++) acc[i] <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        fr <= f; gr <= g; cnt <= '0; run <= 1'b1;
        for (int i = 0; i < 10; i++) acc[i] <= '0;
      end else if (run) begin
        if (cnt == 4'd10) begin
          h <= h_n; done <= 1'b1; run <= 1'b0;
        end else begin
          for (int i = 0; i < 10; i++) acc[i] <= acc_n[i];
          cnt <= cnt + 4'd1;
        end
      end
    end
  end
endmodule

module ge_addsub_unit #(
  parameter int MUL_LANES = 1,
  parameter bit DONE_HOLD = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [319:0] p_X, p_Y, p_Z, p_T,
  input  logic [319:0] q_yplusx, q_yminusx, q_xy2d, q_Z,
  output logic         busy,
  output logic         done,
  output logic [319:0] r_X, r_Y, r_Z, r_T
);
  if (MUL_LANES != 1 && MUL_LANES != 2) begin : g_bad_lanes
    $error("ge_addsub_unit: MUL_LANES must be 1 or 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_MSTART, S_MWAIT, S_FIN_D, S_FIN_XY, S_FIN_ZT, S_DONE} state_t;
  state_t state;

  logic         m_sub, m_cached;
  logic [319:0] lp_X, lp_Y, lp_Z, lp_T, lq_yp, lq_ym, lq_xy, lq_z;
  logic [319:0] ypx, ymx, a, b, c, zz, d;
  logic [1:0]   grp, last_grp;
  logic [319:0] add_a, add_b, add_y, sub_a, sub_b, sub_y;
  logic [1:0]   op_idx   [MUL_LANES];
  logic [319:0] mul_f    [MUL_LANES];
  logic [319:0] mul_g    [MUL_LANES];
  logic [319:0] mul_prod [MUL_LANES];
  logic [MUL_LANES-1:0] mul_done;
  logic         mul_start;

  assign busy      = (state != S_IDLE);
  assign mul_start = (state == S_MSTART);
  assign last_grp  = (MUL_LANES == 2) ? 2'd1 : (m_cached ? 2'd3 : 2'd2);

  // Shared adder/subtractor operands, chosen by the phase being executed.
  always_comb begin
    add_a = '0; add_b = '0; sub_a = '0; sub_b = '0;
    case (state)
      S_PREP:   begin add_a = lp_Y; add_b = lp_X; sub_a = lp_Y; sub_b = lp_X; end
      S_FIN_D:  begin add_a = m_cached ? zz : lp_Z; add_b = m_cached ? zz : lp_Z; end
      S_FIN_XY: begin add_a = a; add_b = b; sub_a = a; sub_b = b; end
      S_FIN_ZT: begin add_a = d; add_b = c; sub_a = d; sub_b = c; end
      default:  ;
    endcase
  end

  fe_add u_add (.a(add_a), .b(add_b), .y(add_y));
  fe_sub u_sub (.a(sub_a), .b(sub_b), .y(sub_y));

  // Product slot per lane (0=A, 1=B, 2=C, 3=ZZ) and its operands; stable for a whole group.
  always_comb begin
    for (int l = 0; l < MUL_LANES; l++) begin
      if (MUL_LANES == 1) op_idx[l] = grp;
      else if (l == 0)    op_idx[l] = (grp == 2'd0) ? 2'd0 : 2'd2;
      else                op_idx[l] = (grp == 2'd0) ? 2'd1 : 2'd3;
      case (op_idx[l])
        2'd0:    begin mul_f[l] = ypx;   mul_g[l] = m_sub ? lq_ym : lq_yp; end
        2'd1:    begin mul_f[l] = ymx;   mul_g[l] = m_sub ? lq_yp : lq_ym; end
        2'd2:    begin mul_f[l] = lq_xy; mul_g[l] = lp_T; end
        default: begin mul_f[l] = lp_Z;  mul_g[l] = lq_z; end
      endcase
    end
  end

  for (genvar l = 0; l < MUL_LANES; l++) begin : g_mul
    fe_mul u_mul (.clk(clk), .reset(reset), .start(mul_start), .f(mul_f[l]), .g(mul_g[l]),
                  .done(mul_done[l]), .h(mul_prod[l]));
  end

  // Sequencer: latch, prep, multiply groups, finish sums, report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE; done <= 1'b0; grp <= '0; m_sub <= 1'b0; m_cached <= 1'b0;
      lp_X <= '0; lp_Y <= '0; lp_Z <= '0; lp_T <= '0;
      lq_yp <= '0; lq_ym <= '0; lq_xy <= '0; lq_z <= '0;
      ypx <= '0; ymx <= '0; a <= '0; b <= '0; c <= '0; zz <= '0; d <= '0;
      r_X <= '0; r_Y <= '0; r_Z <= '0; r_T <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          m_sub <= mode[0]; m_cached <= mode[1];
          lp_X <= p_X; lp_Y <= p_Y; lp_Z <= p_Z; lp_T <= p_T;
          lq_yp <= q_yplusx; lq_ym <= q_yminusx; lq_xy <= q_xy2d;
          lq_z <= q_Z;
          state <= S_PREP;
        end
        S_PREP: begin
          ypx <= add_y; ymx <= sub_y; grp <= '0; state <= S_MSTART;
        end
        S_MSTART: state <= S_MWAIT;
        S_MWAIT: if (&mul_done) begin
          for (int l = 0; l < MUL_LANES; l++) begin
            case (op_idx[l])
              2'd0:    a  <= mul_prod[l];
              2'd1:    b  <= mul_prod[l];
              2'd2:    c  <= mul_prod[l];
              default: zz <= mul_prod[l];
            endcase
          end
          if (grp == last_grp) state <= S_FIN_D;
          else begin grp <= grp + 2'd1; state <= S_MSTART; end
        end
        S_FIN_D:  begin d <= add_y; state <= S_FIN_XY; end
        S_FIN_XY: begin r_X <= sub_y; r_Y <= add_y; state <= S_FIN_ZT; end
        S_FIN_ZT: begin
          r_Z <= m_sub ? sub_y : add_y;
          r_T <= m_sub ? add_y : sub_y;
          done <= 1'b1; state <= S_DONE;
        end
        S_DONE: begin
          if (DONE_HOLD && start) done <= 1'b1;
          else state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ge_addsub_unit.sv
module tb_ge_addsub_unit;
  localparam int LM = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [2:0]   start_v;
  logic [1:0]   mode;
  logic [319:0] pX, pY, pZ, pT, qyp, qym, qxy, qz;
  logic [2:0]   busy_v, done_v;
  logic [319:0] rx [3];
  logic [319:0] ry [3];
  logic [319:0] rz [3];
  logic [319:0] rt [3];
  int nvec = 0;
  int nbad = 0;

  ge_addsub_unit #(.MUL_LANES(1), .DONE_HOLD(1'b0)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .mode(mode),
    .p_X(pX), .p_Y(pY), .p_Z(pZ), .p_T(pT),
    .q_yplusx(qyp), .q_yminusx(qym), .q_xy2d(qxy), .q_Z(qz),
    .busy(busy_v[0]), .done(done_v[0]), .r_X(rx[0]), .r_Y(ry[0]), .r_Z(rz[0]), .r_T(rt[0]));
  ge_addsub_unit #(.MUL_LANES(2), .DONE_HOLD(1'b0)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .mode(mode),
    .p_X(pX), .p_Y(pY), .p_Z(pZ), .p_T(pT),
    .q_yplusx(qyp), .q_yminusx(qym), .q_xy2d(qxy), .q_Z(qz),
    .busy(busy_v[1]), .done(done_v[1]), .r_X(rx[1]), .r_Y(ry[1]), .r_Z(rz[1]), .r_T(rt[1]));
  ge_addsub_unit #(.MUL_LANES(1), .DONE_HOLD(1'b1)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .mode(mode),
    .p_X(pX), .p_Y(pY), .p_Z(pZ), .p_T(pT),
    .q_yplusx(qyp), .q_yminusx(qym), .q_xy2d(qxy), .q_Z(qz),
    .busy(busy_v[2]), .done(done_v[2]), .r_X(rx[2]), .r_Y(ry[2]), .r_Z(rz[2]), .r_T(rt[2]));

  function automatic logic [319:0] fe(input int v);
    logic [319:0] x;
    x = '0;
    x[31:0] = v;
    return x;
  endfunction

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_ops(input logic [1:0] m);
    mode = m;
    pX = fe(1); pY = fe(3); pZ = fe(5); pT = fe(2);
    qyp = fe(7); qym = fe(11); qxy = fe(1); qz = fe(4);
  endtask

  task automatic scramble();
    mode = ~mode;
    pX = fe(9); pY = fe(13); pZ = fe(17); pT = fe(6);
    qyp = fe(3); qym = fe(5); qxy = fe(8); qz = fe(21);
  endtask

  task automatic check_r(input string tag, input int u, input int ex, ey, ez, et);
    check({tag, "_rX"}, rx[u], fe(ex));
    check({tag, "_rY"}, ry[u], fe(ey));
    check({tag, "_rZ"}, rz[u], fe(ez));
    check({tag, "_rT"}, rt[u], fe(et));
  endtask

  // One operation: inputs scrambled the cycle after start, a stray start pulsed mid-run.
  task automatic run_op(input int u, input logic [1:0] m, input int g, input int ex, ey, ez, et);
    string tag;
    int cyc;
    tag = $sformatf("u%0d_m%0d", u, m);
    @(posedge clk); #1;
    load_ops(m);
    start_v[u] = 1'b1;
    @(posedge clk); #1;
    start_v[u] = 1'b0;
    scramble();
    cyc = 1;
    check({tag, "_busy1"}, busy_v[u], 1'b1);
    while (!done_v[u] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 10) start_v[u] = 1'b1;
      if (cyc == 11) start_v[u] = 1'b0;
    end
    check({tag, "_done_cyc"}, cyc, 5 + g * (LM + 1));
    check({tag, "_busy_at_done"}, busy_v[u], 1'b1);
    check_r(tag, u, ex, ey, ez, et);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done_v[u], 1'b0);
    check({tag, "_busy_after"}, busy_v[u], 1'b0);
  endtask

  initial begin
    int cyc;
    reset = 1'b0;
    start_v = '0;
    load_ops(2'b00);
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("rst_busy%0d", u), busy_v[u], 1'b0);
      check($sformatf("rst_done%0d", u), done_v[u], 1'b0);
      check_r($sformatf("rst%0d", u), u, 0, 0, 0, 0);
    end
    reset = 1'b1;

    // all four modes, single and dual lane
    run_op(0, 2'b00, 3, 6, 50, 12, 8);
    run_op(0, 2'b01, 3, 30, 58, 8, 12);
    run_op(0, 2'b10, 4, 6, 50, 42, 38);
    run_op(0, 2'b11, 4, 30, 58, 38, 42);
    run_op(1, 2'b00, 2, 6, 50, 12, 8);
    run_op(1, 2'b01, 2, 30, 58, 8, 12);
    run_op(1, 2'b10, 2, 6, 50, 42, 38);
    run_op(1, 2'b11, 2, 30, 58, 38, 42);

    // back-to-back with start held high
    @(posedge clk); #1;
    load_ops(2'b00);
    start_v[0] = 1'b1;
    cyc = 0;
    while (!done_v[0] && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("b2b_first_cyc", cyc, 5 + 3 * (LM + 1));
    @(posedge clk); #1;
    check("b2b_gap_busy", busy_v[0], 1'b0);
    load_ops(2'b01);
    cyc = 0;
    while (!done_v[0] && cyc < 200) begin @(posedge clk); #1; cyc++; end
    start_v[0] = 1'b0;
    check("b2b_second_cyc", cyc, 5 + 3 * (LM + 1));
    check_r("b2b", 0, 30, 58, 8, 12);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_idle", busy_v[0], 1'b0);

    // reset during MWAIT of the second multiply group
    @(posedge clk); #1;
    load_ops(2'b00);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("mid_busy_before_rst", busy_v[0], 1'b1);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", busy_v[0], 1'b0);
    check("rst_mid_done", done_v[0], 1'b0);
    check_r("rst_mid", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_op(0, 2'b10, 4, 6, 50, 42, 38);

    // legacy hold: done stays while start is high
    @(posedge clk); #1;
    load_ops(2'b01);
    start_v[2] = 1'b1;
    cyc = 0;
    while (!done_v[2] && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("hold_done_cyc", cyc, 5 + 3 * (LM + 1));
    check_r("hold", 2, 30, 58, 8, 12);
    repeat (3) begin
      @(posedge clk); #1;
      check("hold_done_high", done_v[2], 1'b1);
      check("hold_busy_high", busy_v[2], 1'b1);
    end
    start_v[2] = 1'b0;
    check("hold_done_still", done_v[2], 1'b1);
    @(posedge clk); #1;
    check("hold_done_fall", done_v[2], 1'b0);
    check("hold_busy_fall", busy_v[2], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
